// File: rtl/rv_pkg.sv
// Shared RV32 fetch/decode definitions.
// Contents: instruction width, canonical NOP encoding, major opcode enum
// (shared with the immediate generator) and an opcode legality helper.
package rv_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    I_ALU  = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    JAL    = 7'b1101111,
    LUI    = 7'b0110111,
    R_ALU  = 7'b0110011,
    JALR   = 7'b1100111
  } opcode_e;

  function automatic logic op_is_legal(input logic [6:0] op);
    case (op)
      I_ALU, LOAD, STORE, BRANCH, JAL, LUI, R_ALU, JALR: op_is_legal = 1'b1;
      default:                                           op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO holding fetched entries for the fetch unit.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   push_i/push_data_i  write an entry (caller guarantees not full)
//   pop_i            remove the head (ignored when empty)
//   flush_i          empty the FIFO; dominates push and pop
//   head_o           head entry (undefined when empty)
//   count_o, empty_o occupancy
module ifu_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues word fetches under a credit
// limit of DEPTH, tags in-order responses with their request PC, buffers them
// in ifu_fifo and presents {pc, instr, op} to decode. Redirects flush the
// buffer and drop responses of in-flight fetches.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         fetch request channel
//   imem_rsp_valid/data               in-order fetch response, no backpressure
//   redirect_valid/redirect_pc        branch/jump redirect
//   dec_valid/ready, dec_instr/op/pc  decode handshake and head entry
//   dec_illegal                       illegal-encoding flag of head entry
// Build option: define IFU_ILLEGAL_CHECK_EN to compute dec_illegal; otherwise
// it is tied to 0.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [6:0]         dec_op,
  output logic [31:0]        dec_pc,
  output logic               dec_illegal
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;
`ifdef IFU_ILLEGAL_CHECK_EN
  localparam int unsigned FW = 65;
`else
  localparam int unsigned FW = 64;
`endif

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          run_q;
  logic [31:0]   tag_q [DEPTH];
  logic [PW-1:0] tag_wr_q, tag_rd_q;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [FW-1:0] push_data, head;
  logic [SW-1:0] credit_used;
  logic          req_fire, rsp_keep;
  logic [1:0]    unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // run_q keeps the request channel quiet until the first edge after reset.
  assign credit_used    = SW'(out_q) + SW'(drop_q) + SW'(fifo_count);
  assign imem_req_valid = run_q & ~redirect_valid & (credit_used < SW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & ~redirect_valid & (drop_q == '0);

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      // Everything still owed by memory becomes stale; a response arriving
      // now retires one of those stale slots.
      pc_d   = {redirect_pc[31:2], 2'b00};
      out_d  = '0;
      drop_d = drop_q + out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      out_d = out_q + CW'(req_fire) - CW'(rsp_keep);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      run_q  <= 1'b1;
    end
  end

  // PC tags of live (non-stale) outstanding requests, oldest at tag_rd_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else if (redirect_valid) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      if (req_fire) tag_wr_q <= tag_wr_q + PW'(1);
      if (rsp_keep) tag_rd_q <= tag_rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_q[tag_wr_q] <= pc_q;
  end

`ifdef IFU_ILLEGAL_CHECK_EN
  logic rsp_illegal;
  assign rsp_illegal = (imem_rsp_data[1:0] != 2'b11) | ~op_is_legal(imem_rsp_data[6:0]);
  assign push_data   = {rsp_illegal, tag_q[tag_rd_q], imem_rsp_data};
`else
  assign push_data   = {tag_q[tag_rd_q], imem_rsp_data};
`endif

  ifu_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (FW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (rsp_keep),
    .push_data_i (push_data),
    .pop_i       (dec_valid & dec_ready),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign dec_valid = ~fifo_empty;
  assign dec_pc    = fifo_empty ? '0 : head[63:32];
  assign dec_instr = fifo_empty ? NOP_INSTR : head[31:0];
  assign dec_op    = dec_instr[6:0];
`ifdef IFU_ILLEGAL_CHECK_EN
  assign dec_illegal = ~fifo_empty & head[64];
`else
  assign dec_illegal = 1'b0;
`endif

endmodule
